// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave port: default frame width, FSM encoding
// and the cpol/cpha sample-edge decode.
package spi_pkg;

   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

   // An sclk edge is a sample edge when (edge is leading) XOR cpha.
   function automatic logic sample_edge(input logic is_leading, input logic cpha);
      return is_leading ^ cpha;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic pclk,
   input  logic preset_n,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_sync <= {STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_q    = r_sync[STAGES-1];
   assign o_rise =  o_q & ~r_prev;
   assign o_fall = ~o_q &  r_prev;

endmodule

// File: rtl/spi_slave_if.sv
// SPI responder port in the pclk domain: all four cpol/cpha modes, LSB/MSB first.
// Optional overrun detection is built when SPI_SLV_OVR_DET_EN is defined.
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic              spi_en,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsbfe,
   input  logic              sclk,
   input  logic              ss,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
   output logic              busy
`ifdef SPI_SLV_OVR_DET_EN
   ,
   output logic              overrun
`endif
);

   localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic w_sclk_q, w_sclk_rise, w_sclk_fall;
   logic w_ss_q,   w_ss_rise,   w_ss_fall;
   logic w_mosi_q, w_mosi_rise, w_mosi_fall;
   logic w_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .pclk(pclk), .preset_n(preset_n), .i_d(sclk),
      .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .pclk(pclk), .preset_n(preset_n), .i_d(ss),
      .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .pclk(pclk), .preset_n(preset_n), .i_d(mosi),
      .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
   );

   assign w_unused = ^{w_sclk_q, w_mosi_rise, w_mosi_fall};

   spi_state_e        r_state, w_state_nxt;
   logic              w_start;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [DATA_W-1:0] r_tx_shift, r_tx_hold, r_rx_shift, r_rx_data;
   logic              r_tx_ready, r_rx_valid;

   logic w_lead, w_trail, w_sample, w_drive;
   logic w_active_run, w_bit_smp, w_done, w_shift, w_consume, w_load, w_out_bit;
   logic [DATA_W-1:0] w_rx_next;

   assign w_lead   = cpol ? w_sclk_fall : w_sclk_rise;
   assign w_trail  = cpol ? w_sclk_rise : w_sclk_fall;
   assign w_sample = (w_lead  & sample_edge(1'b1, cpha)) |
                     (w_trail & sample_edge(1'b0, cpha));
   assign w_drive  = (w_lead | w_trail) & ~w_sample;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   // NOTE: every output of this block is assigned a default before the case,
   // so no path leaves a value held and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (spi_en && w_ss_fall) begin
               w_state_nxt = ST_ACTIVE;
               w_start     = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!spi_en || w_ss_rise) w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_active_run = (r_state == ST_ACTIVE) & spi_en & ~w_ss_rise;
   assign w_bit_smp    = w_active_run & w_sample;
   assign w_done       = w_bit_smp & (r_bit_cnt == LAST_BIT);
   // The first drive edge of each frame finds the first bit already in place.
   assign w_shift      = w_active_run & w_drive & (r_bit_cnt != '0);
   assign w_consume    = w_start | w_done;
   assign w_load       = tx_load & r_tx_ready;

   assign w_rx_next = lsbfe ? {w_mosi_q, r_rx_shift[DATA_W-1:1]}
                            : {r_rx_shift[DATA_W-2:0], w_mosi_q};

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_bit_cnt  <= '0;
         r_rx_shift <= '0;
      end else begin
         if (w_start || w_done)  r_bit_cnt <= '0;
         else if (w_bit_smp)     r_bit_cnt <= r_bit_cnt + 1'b1;
         if (w_bit_smp)          r_rx_shift <= w_rx_next;
      end
   end

   // Consume happens before load, so a same-cycle load lands in the freed register.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_tx_shift <= '0;
         r_tx_hold  <= '0;
         r_tx_ready <= 1'b1;
      end else begin
         if (w_consume)    r_tx_shift <= r_tx_hold;
         else if (w_shift) r_tx_shift <= lsbfe ? (r_tx_shift >> 1) : (r_tx_shift << 1);
         if (w_load) begin
            r_tx_hold  <= tx_data;
            r_tx_ready <= 1'b0;
         end else if (w_consume) begin
            r_tx_ready <= 1'b1;
         end
      end
   end

`ifdef SPI_SLV_OVR_DET_EN
   logic r_overrun;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_done && r_rx_valid && !rx_ack) begin
            r_overrun <= 1'b1;
         end else if (w_done) begin
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
         end else if (rx_ack) begin
            r_rx_valid <= 1'b0;
         end
         if (rx_ack) r_overrun <= 1'b0;
      end
   end

   assign overrun = r_overrun;
`else
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         if (w_done) begin
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
         end else if (rx_ack) begin
            r_rx_valid <= 1'b0;
         end
      end
   end
`endif

   assign w_out_bit = lsbfe ? r_tx_shift[0] : r_tx_shift[DATA_W-1];
   assign miso_oe   = spi_en & ~w_ss_q;
   assign miso      = miso_oe & w_out_bit;
   assign tx_ready  = r_tx_ready;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign busy      = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: bit-banged SPI master plus rx scoreboard.
// Overrun checks are compiled in when SPI_SLV_OVR_DET_EN is defined.
module tb_spi_slave_if;

   localparam int W = 8;
   localparam int H = 8;   // sclk half period in pclk cycles

   logic         pclk = 1'b0;
   logic         preset_n, spi_en, cpol, cpha, lsbfe, sclk, ss, mosi, tx_load;
   logic [W-1:0] tx_data;
   logic         ack_mon = 1'b0;
   logic         ack_man = 1'b0;
   logic         auto_ack = 1'b1;
   wire          rx_ack = ack_mon | ack_man;
   logic         miso, miso_oe, tx_ready, rx_valid, busy;
   logic [W-1:0] rx_data;
`ifdef SPI_SLV_OVR_DET_EN
   logic         overrun;
`endif

   int           n_checks = 0;
   int           n_errors = 0;
   int           n_rx_seen = 0;
   logic [W-1:0] rx_q[$];

   spi_slave_if #(.DATA_W(W), .SYNC_STAGES(2)) dut (
      .pclk(pclk), .preset_n(preset_n), .spi_en(spi_en),
      .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
      .sclk(sclk), .ss(ss), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
      .busy(busy)
`ifdef SPI_SLV_OVR_DET_EN
      , .overrun(overrun)
`endif
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge pclk);
   endtask

   // Scoreboard consumer: compare each delivered frame, then acknowledge it.
   always @(negedge pclk) begin
      if (ack_mon) begin
         ack_mon = 1'b0;
      end else if (auto_ack && rx_valid) begin
         n_rx_seen++;
         if (rx_q.size() == 0) check("rx_q_nonempty", rx_q.size(), 1);
         else                  check("rx_data", rx_data, rx_q.pop_front());
         ack_mon = 1'b1;
      end
   end

   task automatic set_mode(input logic p, input logic h, input logic l);
      cpol  = p;
      cpha  = h;
      lsbfe = l;
      sclk  = p;
      wait_cyc(6);
   endtask

   task automatic load_tx(input logic [W-1:0] v);
      check("tx_ready_before_load", tx_ready, 1);
      tx_data = v;
      tx_load = 1'b1;
      wait_cyc(1);
      tx_load = 1'b0;
      check("tx_ready_after_load", tx_ready, 0);
   endtask

   task automatic ss_low();
      ss = 1'b0;
      wait_cyc(H);
   endtask

   task automatic ss_high();
      wait_cyc(H);
      ss = 1'b1;
      wait_cyc(H);
   endtask

   // Master side of one frame (nbits < W gives a truncated frame).
   task automatic xfer(input logic [W-1:0] m_out, input int nbits, input logic push,
                       input logic chk, input logic [W-1:0] exp_miso);
      logic [W-1:0] cap;
      cap = '0;
      if (push) rx_q.push_back(m_out);
      for (int i = 0; i < nbits; i++) begin
         int idx;
         idx = lsbfe ? i : W - 1 - i;
         if (!cpha) begin
            mosi = m_out[idx];
            wait_cyc(H);
            cap[idx] = miso;
            sclk = ~cpol;
            wait_cyc(H);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = m_out[idx];
            wait_cyc(H);
            cap[idx] = miso;
            sclk = cpol;
            wait_cyc(H);
         end
      end
      if (chk) check("miso_frame", cap, exp_miso);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_miso"},     miso,     0);
      check({pfx, "_miso_oe"},  miso_oe,  0);
      check({pfx, "_tx_ready"}, tx_ready, 1);
      check({pfx, "_rx_data"},  rx_data,  0);
      check({pfx, "_rx_valid"}, rx_valid, 0);
      check({pfx, "_busy"},     busy,     0);
`ifdef SPI_SLV_OVR_DET_EN
      check({pfx, "_overrun"},  overrun,  0);
`endif
   endtask

   initial begin
      int rx_before;
      preset_n = 1'b0;
      spi_en   = 1'b1;
      cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
      sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
      tx_load = 1'b0; tx_data = '0;
      wait_cyc(3);
      check_reset_outputs("reset");
      preset_n = 1'b1;
      wait_cyc(4);

      // Mode 0, MSB first
      load_tx(8'h3C);
      ss_low();
      check("busy_in_frame", busy, 1);
      check("miso_oe_selected", miso_oe, 1);
      xfer(8'hA5, W, 1'b1, 1'b1, 8'h3C);
      ss_high();
      check("busy_after_ss", busy, 0);
      check("miso_oe_deselected", miso_oe, 0);

      // Mode 3, LSB first
      set_mode(1'b1, 1'b1, 1'b1);
      load_tx(8'h81);
      ss_low();
      xfer(8'h01, W, 1'b1, 1'b1, 8'h81);
      ss_high();

      // Aborted frame, then a full frame re-sending the unchanged holding register
      set_mode(1'b0, 1'b0, 1'b0);
      ss_low();
      xfer(8'hFF, 4, 1'b0, 1'b0, 8'h00);
      ss_high();
      check("busy_after_abort", busy, 0);
      check("rx_valid_after_abort", rx_valid, 0);
      check("tx_ready_resend", tx_ready, 1);
      ss_low();
      xfer(8'h5A, W, 1'b1, 1'b1, 8'h81);
      ss_high();

      // Back-to-back frames under one ss
      rx_before = n_rx_seen;
      load_tx(8'hAA);
      ss_low();
      load_tx(8'h55);
      xfer(8'h11, W, 1'b1, 1'b1, 8'hAA);
      xfer(8'h22, W, 1'b1, 1'b1, 8'h55);
      ss_high();
      check("rx_pulses_b2b", n_rx_seen - rx_before, 2);
      check("tx_ready_after_b2b", tx_ready, 1);

      // Two unacknowledged frames, mode 2
      set_mode(1'b1, 1'b0, 1'b0);
      auto_ack = 1'b0;
      ss_low();
      xfer(8'h11, W, 1'b0, 1'b0, 8'h00);
      xfer(8'h22, W, 1'b0, 1'b0, 8'h00);
      ss_high();
      check("rx_valid_no_ack", rx_valid, 1);
`ifdef SPI_SLV_OVR_DET_EN
      check("rx_data_kept", rx_data, 8'h11);
      check("overrun_set", overrun, 1);
`else
      check("rx_data_overwritten", rx_data, 8'h22);
`endif
      ack_man = 1'b1;
      wait_cyc(1);
      ack_man = 1'b0;
      check("rx_valid_after_ack", rx_valid, 0);
`ifdef SPI_SLV_OVR_DET_EN
      check("overrun_cleared", overrun, 0);
`endif
      auto_ack = 1'b1;

      // Reset mid-frame, mode 1
      set_mode(1'b0, 1'b1, 1'b0);
      ss_low();
      xfer(8'hF0, 4, 1'b0, 1'b0, 8'h00);
      check("busy_mid_frame", busy, 1);
      preset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      wait_cyc(2);
      preset_n = 1'b1;
      ss_high();
      load_tx(8'hC3);
      ss_low();
      xfer(8'h96, W, 1'b1, 1'b1, 8'hC3);
      ss_high();

      wait_cyc(4);
      check("rx_q_drained", rx_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
